// File: rtl/vga_pkg.sv
//------------------------------------------------------------------------------
// Module   : vga_pkg
// Brief    : Default 640x480@25MHz timing constants, phase and coordinate types.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package vga_pkg;

  localparam int c_COORD_W  = 11;

  localparam int c_H_ACTIVE = 640;
  localparam int c_H_FRONT  = 16;
  localparam int c_H_SYNC   = 96;
  localparam int c_H_BACK   = 48;
  localparam int c_H_TOTAL  = c_H_ACTIVE + c_H_FRONT + c_H_SYNC + c_H_BACK;

  localparam int c_V_ACTIVE = 480;
  localparam int c_V_FRONT  = 10;
  localparam int c_V_SYNC   = 2;
  localparam int c_V_BACK   = 33;
  localparam int c_V_TOTAL  = c_V_ACTIVE + c_V_FRONT + c_V_SYNC + c_V_BACK;

  typedef logic [c_COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_t;

endpackage

`default_nettype wire

// File: rtl/vga_axis_counter.sv
//------------------------------------------------------------------------------
// Module   : vga_axis_counter
// Brief    : One timing axis: wrapping coordinate counter plus porch/sync phase FSM.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE = c_H_ACTIVE,
  parameter int FRONT  = c_H_FRONT,
  parameter int SYNC   = c_H_SYNC,
  parameter int BACK   = c_H_BACK
) (
  input  logic   clk,
  input  logic   resetN,
  input  logic   i_advance,
  output coord_t o_count,
  output phase_t o_phase_nxt,
  output logic   o_wrap
);

  localparam coord_t c_LAST     = coord_t'(ACTIVE + FRONT + SYNC + BACK - 1);
  localparam coord_t c_FRONT_AT = coord_t'(ACTIVE);
  localparam coord_t c_SYNC_AT  = coord_t'(ACTIVE + FRONT);
  localparam coord_t c_BACK_AT  = coord_t'(ACTIVE + FRONT + SYNC);

  coord_t r_count;
  coord_t w_count_nxt;
  phase_t r_phase;
  phase_t w_phase_nxt;

  assign o_wrap = (r_count == c_LAST);

  // Phase changes are decided on the upcoming count so the registered outputs
  // built from w_phase_nxt line up with the coordinate they describe.
  always_comb begin
    w_count_nxt = r_count;
    w_phase_nxt = r_phase;
    if (i_advance) begin
      w_count_nxt = o_wrap ? '0 : r_count + coord_t'(1);
      case (r_phase)
        PH_ACTIVE: if (w_count_nxt == c_FRONT_AT) w_phase_nxt = PH_FRONT;
        PH_FRONT:  if (w_count_nxt == c_SYNC_AT)  w_phase_nxt = PH_SYNC;
        PH_SYNC:   if (w_count_nxt == c_BACK_AT)  w_phase_nxt = PH_BACK;
        PH_BACK:   if (w_count_nxt == '0)         w_phase_nxt = PH_ACTIVE;
        default:   w_phase_nxt = PH_BACK;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_count <= c_LAST;
      r_phase <= PH_BACK;
    end else begin
      r_count <= w_count_nxt;
      r_phase <= w_phase_nxt;
    end
  end

  assign o_count     = r_count;
  assign o_phase_nxt = w_phase_nxt;

endmodule

`default_nettype wire

// File: rtl/vga_sync_gen.sv
//------------------------------------------------------------------------------
// Module   : vga_sync_gen
// Brief    : VGA raster coordinate, sync and display-enable generator.
//            Define VGA_PIXEL_DIV2_EN to advance one pixel every second clk.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = c_H_ACTIVE,
  parameter int H_FRONT  = c_H_FRONT,
  parameter int H_SYNC   = c_H_SYNC,
  parameter int H_BACK   = c_H_BACK,
  parameter int V_ACTIVE = c_V_ACTIVE,
  parameter int V_FRONT  = c_V_FRONT,
  parameter int V_SYNC   = c_V_SYNC,
  parameter int V_BACK   = c_V_BACK
) (
  input  logic                 clk,
  input  logic                 resetN,
  output logic [c_COORD_W-1:0] pixelX,
  output logic [c_COORD_W-1:0] pixelY,
  output logic                 hSync,
  output logic                 vSync,
  output logic                 displayEn,
  output logic                 startOfFrame,
  output logic                 endOfLine
);

  // endOfLine is registered, so it is raised while the current count is one short.
  localparam coord_t c_EOL_PRE = coord_t'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 2);

  logic   w_adv;
  logic   w_h_wrap;
  logic   w_v_wrap;
  coord_t w_h_count;
  coord_t w_v_count;
  phase_t w_h_phase_nxt;
  phase_t w_v_phase_nxt;

  logic r_hsync;
  logic r_vsync;
  logic r_disp_en;
  logic r_sof;
  logic r_eol;

`ifdef VGA_PIXEL_DIV2_EN
  logic r_div;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) r_div <= 1'b0;
    else         r_div <= ~r_div;
  end

  assign w_adv = r_div;
`else
  assign w_adv = 1'b1;
`endif

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FRONT  (H_FRONT),
    .SYNC   (H_SYNC),
    .BACK   (H_BACK)
  ) u_h_axis (
    .clk         (clk),
    .resetN      (resetN),
    .i_advance   (w_adv),
    .o_count     (w_h_count),
    .o_phase_nxt (w_h_phase_nxt),
    .o_wrap      (w_h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FRONT  (V_FRONT),
    .SYNC   (V_SYNC),
    .BACK   (V_BACK)
  ) u_v_axis (
    .clk         (clk),
    .resetN      (resetN),
    .i_advance   (w_h_wrap & w_adv),
    .o_count     (w_v_count),
    .o_phase_nxt (w_v_phase_nxt),
    .o_wrap      (w_v_wrap)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_hsync   <= 1'b1;
      r_vsync   <= 1'b1;
      r_disp_en <= 1'b0;
      r_sof     <= 1'b0;
      r_eol     <= 1'b0;
    end else if (w_adv) begin
      r_hsync   <= (w_h_phase_nxt != PH_SYNC);
      r_vsync   <= (w_v_phase_nxt != PH_SYNC);
      r_disp_en <= (w_h_phase_nxt == PH_ACTIVE) && (w_v_phase_nxt == PH_ACTIVE);
      r_sof     <= w_h_wrap && w_v_wrap;
      r_eol     <= (w_h_count == c_EOL_PRE);
    end
  end

  assign pixelX       = w_h_count;
  assign pixelY       = w_v_count;
  assign hSync        = r_hsync;
  assign vSync        = r_vsync;
  assign displayEn    = r_disp_en;
  assign startOfFrame = r_sof;
  assign endOfLine    = r_eol;

endmodule

`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
//------------------------------------------------------------------------------
// Module   : tb_vga_sync_gen
// Brief    : Self-checking bench: default-timing and reduced-timing instances.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_vga_sync_gen;

`ifdef VGA_PIXEL_DIV2_EN
  localparam int DIV = 2;
`else
  localparam int DIV = 1;
`endif

  localparam int HA_D = 640, HF_D = 16, HS_D = 96, HT_D = 800;
  localparam int VA_D = 480, VF_D = 10, VS_D = 2,  VT_D = 525;
  localparam int HA_S = 10,  HF_S = 2,  HS_S = 3,  HB_S = 1, HT_S = 16;
  localparam int VA_S = 6,   VF_S = 1,  VS_S = 2,  VB_S = 1, VT_S = 10;
  localparam int FR_S = HT_S * VT_S;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic        hs;
    logic        vs;
    logic        de;
    logic        sof;
    logic        eol;
  } obs_t;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  logic [10:0] px_d, py_d, px_s, py_s;
  logic hs_d, vs_d, de_d, sof_d, eol_d;
  logic hs_s, vs_s, de_s, sof_s, eol_s;

  vga_sync_gen dut_d (
    .clk(clk), .resetN(resetN), .pixelX(px_d), .pixelY(py_d), .hSync(hs_d), .vSync(vs_d),
    .displayEn(de_d), .startOfFrame(sof_d), .endOfLine(eol_d)
  );

  vga_sync_gen #(
    .H_ACTIVE(HA_S), .H_FRONT(HF_S), .H_SYNC(HS_S), .H_BACK(HB_S),
    .V_ACTIVE(VA_S), .V_FRONT(VF_S), .V_SYNC(VS_S), .V_BACK(VB_S)
  ) dut_s (
    .clk(clk), .resetN(resetN), .pixelX(px_s), .pixelY(py_s), .hSync(hs_s), .vSync(vs_s),
    .displayEn(de_s), .startOfFrame(sof_s), .endOfLine(eol_s)
  );

  obs_t obs_d, obs_s;
  assign obs_d = {px_d, py_d, hs_d, vs_d, de_d, sof_d, eol_d};
  assign obs_s = {px_s, py_s, hs_s, vs_s, de_s, sof_s, eol_s};

  int n_checks = 0;
  int n_pass   = 0;

  // Expected outputs derived directly from the raster coordinate.
  function automatic obs_t exp_of(int x, int y, int ha, int hf, int hs, int ht,
                                  int va, int vf, int vs);
    obs_t e;
    e.x   = 11'(x);
    e.y   = 11'(y);
    e.hs  = !((x >= ha + hf) && (x < ha + hf + hs));
    e.vs  = !((y >= va + vf) && (y < va + vf + vs));
    e.de  = (x < ha) && (y < va);
    e.sof = (x == 0) && (y == 0);
    e.eol = (x == ht - 1);
    return e;
  endfunction

  function automatic obs_t exp_d(int x, int y);
    return exp_of(x, y, HA_D, HF_D, HS_D, HT_D, VA_D, VF_D, VS_D);
  endfunction

  function automatic obs_t exp_s(int x, int y);
    return exp_of(x, y, HA_S, HF_S, HS_S, HT_S, VA_S, VF_S, VS_S);
  endfunction

  function automatic obs_t rst_of(int ht, int vt);
    return {11'(ht - 1), 11'(vt - 1), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  endfunction

  // Reference model and scoreboard: one expected entry per clk edge.
  obs_t q_d[$];
  obs_t q_s[$];
  obs_t m_exp_d, m_exp_s, e_d, e_s;
  int   mx_d = HT_D - 1, my_d = VT_D - 1, mx_s = HT_S - 1, my_s = VT_S - 1;
  int   nx, ny;
  bit   m_tog = 1'b0;
  bit   m_adv;

  initial begin : p_model
    m_exp_d = rst_of(HT_D, VT_D);
    m_exp_s = rst_of(HT_S, VT_S);
    forever begin
      @(posedge clk or negedge resetN);
      if (!resetN) begin
        mx_d = HT_D - 1; my_d = VT_D - 1;
        mx_s = HT_S - 1; my_s = VT_S - 1;
        m_tog = 1'b0;
        m_exp_d = rst_of(HT_D, VT_D);
        m_exp_s = rst_of(HT_S, VT_S);
        q_d.delete();
        q_s.delete();
      end else begin
        m_adv = (DIV == 1) || m_tog;
        m_tog = !m_tog;
        if (m_adv) begin
          ny = (mx_d == HT_D - 1) ? ((my_d == VT_D - 1) ? 0 : my_d + 1) : my_d;
          nx = (mx_d == HT_D - 1) ? 0 : mx_d + 1;
          mx_d = nx; my_d = ny;
          ny = (mx_s == HT_S - 1) ? ((my_s == VT_S - 1) ? 0 : my_s + 1) : my_s;
          nx = (mx_s == HT_S - 1) ? 0 : mx_s + 1;
          mx_s = nx; my_s = ny;
          m_exp_d = exp_d(mx_d, my_d);
          m_exp_s = exp_s(mx_s, my_s);
        end
        q_d.push_back(m_exp_d);
        q_s.push_back(m_exp_s);
      end
    end
  end

  initial begin : p_monitor
    forever begin
      @(negedge clk);
      if (!resetN) begin
        n_checks += 2;
        if (obs_d !== rst_of(HT_D, VT_D)) $display("FAIL sb_reset_d: got %h want %h", obs_d, rst_of(HT_D, VT_D));
        else n_pass++;
        if (obs_s !== rst_of(HT_S, VT_S)) $display("FAIL sb_reset_s: got %h want %h", obs_s, rst_of(HT_S, VT_S));
        else n_pass++;
      end else if (q_d.size() == 0 || q_s.size() == 0) begin
        n_checks++;
        $display("FAIL sb_underflow: got empty queue want pending entry at %0t", $time);
      end else begin
        e_d = q_d.pop_front();
        e_s = q_s.pop_front();
        n_checks += 2;
        if (obs_d !== e_d) $display("FAIL sb_d: got %h want %h at %0t", obs_d, e_d, $time);
        else n_pass++;
        if (obs_s !== e_s) $display("FAIL sb_s: got %h want %h at %0t", obs_s, e_s, $time);
        else n_pass++;
      end
    end
  end

  task automatic test_reset();
    resetN = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (obs_d !== rst_of(HT_D, VT_D)) $display("FAIL reset_values: got %h want %h", obs_d, rst_of(HT_D, VT_D));
    else n_pass++;
    @(negedge clk);
    #2 resetN = 1'b1;
`ifdef VGA_PIXEL_DIV2_EN
    @(posedge clk); #1;
    n_checks++;
    if (px_d !== 11'd799) $display("FAIL first_edge_hold: got pixelX=%0d want 799", px_d);
    else n_pass++;
`endif
    @(posedge clk); #1;
    n_checks += 2;
    if (px_d !== 11'd0 || py_d !== 11'd0) $display("FAIL first_advance_xy: got (%0d,%0d) want (0,0)", px_d, py_d);
    else n_pass++;
    if ({hs_d, vs_d, de_d, sof_d, eol_d} !== 5'b11110)
      $display("FAIL first_advance_flags: got %b want 11110", {hs_d, vs_d, de_d, sof_d, eol_d});
    else n_pass++;
    repeat (DIV) @(posedge clk);
    #1;
    n_checks++;
    if (px_d !== 11'd1 || sof_d !== 1'b0) $display("FAIL second_pixel: got x=%0d sof=%b want x=1 sof=0", px_d, sof_d);
    else n_pass++;
  endtask

  task automatic test_line();
    int hs_low = 0, hs_min = 9999, hs_max = -1, de_cnt = 0, de_off = -1, eol_cnt = 0, eol_bad = 0;
    bit done = 1'b0;
    bit eol_prev = 1'b0;
    for (int k = 0; k < 2000 * DIV && !done; k++) begin
      if (py_d !== 11'd0) begin
        done = 1'b1;
      end else begin
        if (!hs_d) begin
          hs_low++;
          if (int'(px_d) < hs_min) hs_min = int'(px_d);
          if (int'(px_d) > hs_max) hs_max = int'(px_d);
        end
        if (de_d) de_cnt++;
        else if (de_off < 0) de_off = int'(px_d);
        if (eol_d) begin
          eol_cnt++;
          if (px_d !== 11'd799) eol_bad++;
        end
        eol_prev = eol_d;
        @(posedge clk); #1;
      end
    end
    n_checks += 8;
    if (!done) $display("FAIL line_timeout: got no line wrap want wrap within budget");
    else n_pass++;
    if (px_d !== 11'd0 || py_d !== 11'd1) $display("FAIL line_wrap: got (%0d,%0d) want (0,1)", px_d, py_d);
    else n_pass++;
    if (hs_low !== 96 * DIV) $display("FAIL hsync_width: got %0d want %0d", hs_low, 96 * DIV);
    else n_pass++;
    if (hs_min !== 656 || hs_max !== 751) $display("FAIL hsync_window: got %0d..%0d want 656..751", hs_min, hs_max);
    else n_pass++;
    if (de_off !== 640) $display("FAIL de_fall: got pixelX=%0d want 640", de_off);
    else n_pass++;
    if (de_cnt !== 639 * DIV) $display("FAIL de_count: got %0d want %0d", de_cnt, 639 * DIV);
    else n_pass++;
    if (eol_cnt !== DIV || eol_bad !== 0) $display("FAIL eol_pulse: got cnt=%0d bad=%0d want cnt=%0d bad=0", eol_cnt, eol_bad, DIV);
    else n_pass++;
    if (eol_prev !== 1'b1) $display("FAIL eol_before_wrap: got %b want 1", eol_prev);
    else n_pass++;
  endtask

  task automatic test_frame();
    int t0 = -1, vs_low = 0, vy_min = 9999, vy_max = -1, de_cnt = 0;
    int px_prev = -1, py_prev = -1;
    bit eol_prev = 1'b0, sof_prev = 1'b1, done = 1'b0;
    for (int k = 0; k < 4 * FR_S * DIV && !done; k++) begin
      @(posedge clk); #1;
      if (sof_s && !sof_prev) begin
        if (t0 < 0) begin
          t0 = k;
        end else begin
          done = 1'b1;
          n_checks += 6;
          if (k - t0 !== FR_S * DIV) $display("FAIL sof_period: got %0d want %0d", k - t0, FR_S * DIV);
          else n_pass++;
          if (px_prev !== 15 || py_prev !== 9 || eol_prev !== 1'b1)
            $display("FAIL frame_wrap_prev: got (%0d,%0d) eol=%b want (15,9) eol=1", px_prev, py_prev, eol_prev);
          else n_pass++;
          if (px_s !== 11'd0 || py_s !== 11'd0 || de_s !== 1'b1 || hs_s !== 1'b1 || vs_s !== 1'b1)
            $display("FAIL frame_wrap_next: got (%0d,%0d) de=%b hs=%b vs=%b want (0,0) 1 1 1",
                     px_s, py_s, de_s, hs_s, vs_s);
          else n_pass++;
          if (vs_low !== VS_S * HT_S * DIV) $display("FAIL vsync_width: got %0d want %0d", vs_low, VS_S * HT_S * DIV);
          else n_pass++;
          if (vy_min !== 7 || vy_max !== 8) $display("FAIL vsync_window: got %0d..%0d want 7..8", vy_min, vy_max);
          else n_pass++;
          if (de_cnt !== HA_S * VA_S * DIV) $display("FAIL de_frame: got %0d want %0d", de_cnt, HA_S * VA_S * DIV);
          else n_pass++;
        end
      end
      if (t0 >= 0 && !done) begin
        if (!vs_s) begin
          vs_low++;
          if (int'(py_s) < vy_min) vy_min = int'(py_s);
          if (int'(py_s) > vy_max) vy_max = int'(py_s);
        end
        if (de_s) de_cnt++;
      end
      px_prev = int'(px_s); py_prev = int'(py_s);
      eol_prev = eol_s; sof_prev = sof_s;
    end
    n_checks++;
    if (!done) $display("FAIL frame_timeout: got no full frame want one within budget");
    else n_pass++;
  endtask

  task automatic test_midframe_reset();
    bit found = 1'b0;
    for (int k = 0; k < 2 * FR_S * DIV && !found; k++) begin
      @(posedge clk); #1;
      if (!hs_s) found = 1'b1;
    end
    n_checks++;
    if (!found) $display("FAIL sync_wait_timeout: got no hSync low want one");
    else n_pass++;
    @(negedge clk);
    #2 resetN = 1'b0;
    #1;
    n_checks += 2;
    if (obs_d !== rst_of(HT_D, VT_D)) $display("FAIL midreset_d: got %h want %h", obs_d, rst_of(HT_D, VT_D));
    else n_pass++;
    if (obs_s !== rst_of(HT_S, VT_S)) $display("FAIL midreset_s: got %h want %h", obs_s, rst_of(HT_S, VT_S));
    else n_pass++;
    repeat (3) @(negedge clk);
    #2 resetN = 1'b1;
    repeat (DIV) @(posedge clk);
    #1;
    n_checks += 2;
    if (obs_d !== exp_d(0, 0)) $display("FAIL restart_d: got %h want %h", obs_d, exp_d(0, 0));
    else n_pass++;
    if (obs_s !== exp_s(0, 0)) $display("FAIL restart_s: got %h want %h", obs_s, exp_s(0, 0));
    else n_pass++;
    repeat (2 * HT_S * DIV) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_midframe_reset();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Pixel-timing generator for the VGA output path.
- Produces the pixelX/pixelY raster coordinates consumed by the background draw, object draw and mux stages, plus hSync/vSync and the display-enable.
- Default timing is 640x480 at a 25 MHz pixel rate.
- Horizontal and vertical timing are each tracked by a counter plus a phase state machine.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)

Ports:
- clk  in  1  system clock; one clock domain.
- resetN  in  1  asynchronous, active-low reset.
- pixelX  out  11  current horizontal count, 0..H_TOTAL-1.
- pixelY  out  11  current vertical count, 0..V_TOTAL-1.
- hSync  out  1  horizontal sync, active low.
- vSync  out  1  vertical sync, active low.
- displayEn  out  1  high when pixelX < H_ACTIVE and pixelY < V_ACTIVE.
- startOfFrame  out  1  one-cycle pulse while pixelX==0 and pixelY==0.
- endOfLine  out  1  one-cycle pulse while pixelX==H_TOTAL-1.

Behaviour:
- Totals: H_TOTAL = sum of the four H parameters (800); V_TOTAL = sum of the four V parameters (525).
- Reset values (asynchronous, held while resetN=0):
  - pixelX = H_TOTAL-1 (799), pixelY = V_TOTAL-1 (524)
  - hSync = 1, vSync = 1, displayEn = 0, startOfFrame = 0, endOfLine = 0
- First advance after reset release: counters go to (0,0), with displayEn=1 and startOfFrame=1 on that cycle.
- Advance rule: on each advance cycle the horizontal counter increments. At H_TOTAL-1 it wraps to 0, and on that same edge the vertical counter increments. The vertical counter wraps at V_TOTAL-1.
- Both counters are 11 bits; no arithmetic beyond +1 and compare-equal is used.
- Horizontal phase FSM, states H_ACTIVE, H_FRONT, H_SYNC, H_BACK:
  - H_ACTIVE -> H_FRONT when the next count equals H_ACTIVE
  - H_FRONT -> H_SYNC at H_ACTIVE+H_FRONT
  - H_SYNC -> H_BACK at H_ACTIVE+H_FRONT+H_SYNC
  - H_BACK -> H_ACTIVE on wrap to 0
  - Reset state: H_BACK.
- Vertical phase FSM: identical structure with the V parameters. It transitions only on horizontal wrap. Reset state: V_BACK.
- Output timing: all outputs are registered and decoded from the next-count/next-state, so they are aligned to pixelX/pixelY in the same cycle with zero skew. There is no latency between a coordinate and its flags.
  - hSync = 0 exactly while the H phase is H_SYNC (pixelX 656..751).
  - vSync = 0 exactly while the V phase is V_SYNC (pixelY 490..491).
- Boundaries:
  - Frame wrap, (799,524) -> (0,0): both FSMs change state on the same edge.
  - endOfLine at (799,y) and startOfFrame at (0,0) occur on consecutive cycles.
- Reset mid-frame: all registers return to reset values immediately. The next frame starts cleanly at (0,0) on the first advance; no partial sync pulse is extended.

Optional Feature:
- Macro: VGA_PIXEL_DIV2_EN
- Defined (clk is 50 MHz):
  - An internal toggle flop, reset to 0, generates the advance strobe on every second clk cycle.
  - Counters, FSMs and outputs hold on non-advance cycles, so each pixel lasts 2 clk cycles.
  - startOfFrame and endOfLine are asserted for both clk cycles of their pixel.
  - The first advance occurs on the second clk edge after reset release.
- Undefined: advance every clk cycle; no toggle flop exists.

Decomposition:
- Package vga_pkg:
  - default timing constants and derived H_TOTAL/V_TOTAL
  - phase enum typedef {PH_ACTIVE, PH_FRONT, PH_SYNC, PH_BACK}
  - 11-bit coordinate typedef
- Sub-module vga_axis_counter, instantiated once per axis:
  - parameters ACTIVE/FRONT/SYNC/BACK
  - inputs: advance
  - outputs: count, phase, wrap
  - The vertical instance's advance = horizontal wrap AND advance strobe.

Test Plan:
- Reset release -> first active edge gives pixelX=0, pixelY=0, displayEn=1, startOfFrame=1, hSync=1, vSync=1; next cycle pixelX=1, startOfFrame=0.
- Run one line -> displayEn falls when pixelX=640; hSync=0 for exactly 96 cycles, pixelX 656..751; endOfLine=1 only at pixelX=799; pixelY increments 0->1 at the next edge.
- Run one full frame -> vSync=0 for exactly 1600 cycles, pixelY 490..491; startOfFrame period = 420000 cycles; displayEn high 307200 cycles per frame.
- Frame wrap -> (799,524) followed by (0,0); both phases return to ACTIVE on the same edge.
- Assert resetN=0 at (300,200) -> outputs immediately (799,524), hSync=1, vSync=1, displayEn=0; after release the frame restarts at (0,0).
- With VGA_PIXEL_DIV2_EN -> each pixelX value persists 2 clk cycles; full frame = 840000 cycles; the hSync low window is 192 cycles.
